// File: rtl/slave_wr_demux_if.sv
// Write-request bus between the register-block slave and the write demux,
// carrying the storage read-back and per-write completion strobes.
interface slave_wr_demux_if #(
  parameter int W_WIDTH = 32,
  parameter int W_CNT   = 5
);
  logic                       wr_req;
  logic [W_CNT-1:0]           wr_words;
  logic [W_WIDTH-1:0]         wr_data;
  logic [W_WIDTH/8-1:0]       wr_be;
  logic [W_WIDTH*W_CNT-1:0]   hw_set;
  logic [W_WIDTH*W_CNT-1:0]   all_words;
  logic [W_CNT-1:0]           wr_pulse;
  logic                       wr_ack;
  logic                       wr_err;

  modport master (
    output wr_req, wr_words, wr_data, wr_be, hw_set,
    input  all_words, wr_pulse, wr_ack, wr_err
  );

  modport slave (
    input  wr_req, wr_words, wr_data, wr_be, hw_set,
    output all_words, wr_pulse, wr_ack, wr_err
  );
endinterface

// File: rtl/slave_wr_demux.sv
// Register-bank write demux: capture request, apply byte-enabled/masked write one edge later.
// Two-edge latency (storage at N+1, ack/err/pulse N+1..N+2); one write per cycle, never stalls.
module slave_wr_demux #(
  parameter int                         W_WIDTH  = 32,
  parameter int                         W_CNT    = 5,
  parameter logic [W_WIDTH*W_CNT-1:0]   RST_VAL  = '0,
  parameter logic [W_WIDTH*W_CNT-1:0]   WR_MASK  = '1,
  parameter logic [W_WIDTH*W_CNT-1:0]   W1C_MASK = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  slave_wr_demux_if.slave  bus
);
  localparam int BE_W = W_WIDTH / 8;
  localparam int TOT  = W_WIDTH * W_CNT;

  logic                 req_q;
  logic                 ok_q;
  logic [W_CNT-1:0]     words_q;
  logic [W_WIDTH-1:0]   data_q;
  logic [BE_W-1:0]      be_q;

  logic [TOT-1:0]       store_q;
  logic [TOT-1:0]       store_d;
  logic [W_CNT-1:0]     pulse_q;
  logic                 ack_q;
  logic                 err_q;

  logic                 one_hot;
  logic                 apply;
  logic [W_WIDTH-1:0]   lane_mask;
  logic [W_WIDTH-1:0]   wen;
  logic [W_WIDTH-1:0]   ld;
  logic [W_WIDTH-1:0]   clr;
  logic [W_WIDTH-1:0]   cur;

  assign one_hot = (bus.wr_words != '0) &&
                   ((bus.wr_words & (bus.wr_words - W_CNT'(1))) == '0);
  assign apply   = req_q && ok_q;

  // Stage 1: capture the request and its legality.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      ok_q    <= 1'b0;
      words_q <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      req_q <= bus.wr_req;
      if (bus.wr_req) begin
        ok_q    <= one_hot;
        words_q <= bus.wr_words;
        data_q  <= bus.wr_data;
        be_q    <= bus.wr_be;
      end
    end
  end

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < BE_W; b++) begin
      lane_mask[8*b +: 8] = {8{be_q[b]}};
    end
  end

  // Stage 2: per-word next value; hw_set is OR-ed last so it wins over a same-edge clear.
  always_comb begin
    store_d = store_q;
    wen     = '0;
    ld      = '0;
    clr     = '0;
    cur     = '0;
    for (int i = 0; i < W_CNT; i++) begin
      cur = store_q[i*W_WIDTH +: W_WIDTH];
      wen = (apply && words_q[i]) ? (lane_mask & WR_MASK[i*W_WIDTH +: W_WIDTH]) : '0;
      ld  = wen & ~W1C_MASK[i*W_WIDTH +: W_WIDTH];
      clr = wen & W1C_MASK[i*W_WIDTH +: W_WIDTH] & data_q;
      store_d[i*W_WIDTH +: W_WIDTH] = (((cur & ~ld) | (data_q & ld)) & ~clr)
                                      | bus.hw_set[i*W_WIDTH +: W_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= RST_VAL;
      pulse_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      store_q <= store_d;
      pulse_q <= apply ? words_q : '0;
      ack_q   <= apply;
      err_q   <= req_q && !ok_q;
    end
  end

  assign bus.all_words = store_q;
  assign bus.wr_pulse  = pulse_q;
  assign bus.wr_ack    = ack_q;
  assign bus.wr_err    = err_q;
endmodule

// File: doc/slave_wr_demux.md
# slave_wr_demux

Write-side companion of the register-block read mux. It decodes a one-hot word-select write request and applies byte-enabled data to a bank of `W_CNT` storage words, honouring per-bit writable and write-1-to-clear masks plus hardware set inputs. It owns the storage flops and drives the flattened `all_words` bus that the read mux selects from. It also generates per-word write strobes and a registered ack/error pulse for the bus slave.

## Interface
- `W_WIDTH`, default 32: word width in bits; must be a multiple of 8.
- `W_CNT`, default 5: number of words.
- `RST_VAL`, default all 0 (`W_WIDTH*W_CNT` bits): storage reset value, word i at bits [i*W_WIDTH +: W_WIDTH].
- `WR_MASK`, default all 1 (`W_WIDTH*W_CNT` bits): per-bit software-writable mask; 0 = read-only to software.
- `W1C_MASK`, default all 0 (`W_WIDTH*W_CNT` bits): per-bit write-1-to-clear mask; only effective where `WR_MASK`=1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_req` in 1: write request, one-cycle qualifier.
- `wr_words` in `W_CNT`: one-hot target word select.
- `wr_data` in `W_WIDTH`: write data.
- `wr_be` in `W_WIDTH/8`: byte enables; lane b covers bits [8b+7:8b].
- `hw_set` in `W_WIDTH*W_CNT`: per-bit hardware set, level, sampled every cycle.
- `all_words` out `W_WIDTH*W_CNT`: storage contents, driven directly from flops.
- `wr_pulse` out `W_CNT`: one-cycle strobe for the word that was just updated.
- `wr_ack` out 1: one-cycle pulse for a completed, legal write.
- `wr_err` out 1: one-cycle pulse for a rejected write.

## Operation
- Stage 1 (capture): on each edge with `wr_req`=1, register `wr_words`, `wr_data` and `wr_be`, and set `req_q`=1.
  - Legality check: `wr_words` exactly one-hot. The check result is registered as `ok_q`.
  - With `wr_req`=0, `req_q` becomes 0 and the captured fields hold.
- Stage 2 (apply): on the edge where `req_q`=1 and `ok_q`=1, update the selected word i. For each bit j in enabled byte lane b:
  - `WR_MASK`=0: bit holds.
  - `WR_MASK`=1 and `W1C_MASK`=1: data bit 1 clears the bit; data bit 0 leaves it unchanged.
  - `WR_MASK`=1 and `W1C_MASK`=0: bit takes the data bit.
  - Disabled lanes hold. Unselected words hold.
- `hw_set`: any bit with `hw_set`=1 becomes 1 on that edge, independent of `WR_MASK`. It takes priority over a same-edge software write or clear, so no event is lost.
- On the stage-2 apply edge, `wr_pulse[i]` and `wr_ack` register to 1 for one cycle.
- Illegal request (zero or multiple bits set in `wr_words`): no storage change, `wr_pulse` stays 0, and `wr_err` pulses instead of `wr_ack`.
  - `wr_be`=0 with a one-hot select counts as legal: `wr_ack` and `wr_pulse` assert, data is unchanged.
- Reset:
  - Storage loads `RST_VAL`.
  - `req_q`, `ok_q`, `wr_pulse`, `wr_ack`, `wr_err` reset to 0.
  - Captured data/select/byte-enable registers reset to 0.
- Reset mid-operation: a request in stage 1 or stage 2 is dropped, with no ack, no err and no storage update after reset release.

## Timing
- Request sampled at edge N.
- Storage updated at edge N+1; new value visible on `all_words` from N+1.
- `wr_ack`/`wr_err`/`wr_pulse` high for the cycle between edges N+1 and N+2.
- Throughput: one write per cycle, back-to-back, no stall and no backpressure.
- Consecutive writes to the same word apply in request order. A read issued in cycle N+1 or later observes the update.
- `hw_set` acts in the same cycle it is sampled (edge M updates storage), with no pipeline.

## Test plan
- Reset, then release with no stimulus → `all_words`=`RST_VAL`; `wr_ack`=`wr_err`=0 and `wr_pulse`=0 for 10 cycles.
- `wr_req` with `wr_words`=5'b00100, `wr_data`=32'hDEADBEEF, `wr_be`=4'hF, default masks → word 2 reads 32'hDEADBEEF at N+1; `wr_ack`=1 and `wr_pulse`=5'b00100 for exactly one cycle; other words unchanged.
- Word 1 preloaded 32'h11223344, write 32'hAABBCCDD with `wr_be`=4'b0101 → word 1 becomes 32'h11BB33DD. With `WR_MASK` word 1 = 32'h0000FFFF and `wr_be`=4'hF → word 1 becomes 32'h1122CCDD.
- W1C: word 0 at 32'h000000FF, `W1C_MASK` word 0 = 32'hFF, write 32'h0F → word 0 becomes 32'hF0. Repeat the same write with `hw_set` bit 0 high on the apply edge → bit 0 stays 1, giving 32'hF1.
- `wr_words`=5'b00110, then 5'b00000 → two `wr_err` pulses, no `wr_ack`, `all_words` unchanged.
- Writes on 3 consecutive cycles to words 0, 3, 0 with data 1, 2, 3 → three `wr_ack` pulses on consecutive cycles; final word 0 = 3, word 3 = 2. Assert `rst_n` in the cycle after the third request → no third ack, and after release word 0 = `RST_VAL` word 0.
